// File: rtl/tour_pkg.sv
// Shared constants, state encoding and knight-move geometry for the tour command sequencer.
package tour_pkg;

    localparam int unsigned CMD_W  = 16;
    localparam int unsigned RESP_W = 8;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    localparam logic [RESP_W-1:0] RESP_IDLE = 8'hA5;
    localparam logic [RESP_W-1:0] RESP_ACK  = 8'h5A;
    localparam logic [RESP_W-1:0] RESP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VERT,
        ST_HOLDV,
        ST_HORZ,
        ST_HOLDH
    } state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] heading;
        logic [3:0] squares;
    } cmd_t;

    typedef struct packed {
        logic signed [2:0] dx;
        logic signed [2:0] dy;
    } delta_t;

    // Board displacement for each one-hot move bit.
    function automatic delta_t move_delta(input logic [2:0] bit_idx);
        delta_t d;
        case (bit_idx)
            3'd0:    begin d.dx =  3'sd1; d.dy =  3'sd2; end
            3'd1:    begin d.dx = -3'sd1; d.dy =  3'sd2; end
            3'd2:    begin d.dx = -3'sd2; d.dy =  3'sd1; end
            3'd3:    begin d.dx = -3'sd2; d.dy = -3'sd1; end
            3'd4:    begin d.dx = -3'sd1; d.dy = -3'sd2; end
            3'd5:    begin d.dx =  3'sd1; d.dy = -3'sd2; end
            3'd6:    begin d.dx =  3'sd2; d.dy = -3'sd1; end
            default: begin d.dx =  3'sd2; d.dy =  3'sd1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tour_cmd_seq_decode.sv
// Combinational knight-move decoder: one-hot move to vertical/horizontal command words.
module knight_move_decode
    import tour_pkg::*;
#(
    parameter int unsigned FANFARE_LEG = 1
) (
    input  logic [7:0]       move,
    output logic [CMD_W-1:0] vert_cmd,
    output logic [CMD_W-1:0] horz_cmd,
    output logic             illegal
);

    logic [2:0] bit_idx;
    delta_t     d;
    logic [2:0] dx_mag;
    logic [2:0] dy_mag;
    cmd_t       v_cmd;
    cmd_t       h_cmd;

    // Highest set bit; only meaningful when the move is one-hot.
    always_comb begin
        bit_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (move[i]) bit_idx = 3'(i);
        end
    end

    assign d      = move_delta(bit_idx);
    assign dx_mag = d.dx[2] ? 3'(~d.dx + 3'd1) : 3'(d.dx);
    assign dy_mag = d.dy[2] ? 3'(~d.dy + 3'd1) : 3'(d.dy);

    always_comb begin
        v_cmd.opcode  = (FANFARE_LEG == 0) ? OP_FANFARE : OP_MOVE;
        v_cmd.heading = d.dy[2] ? HEAD_S : HEAD_N;
        v_cmd.squares = 4'(dy_mag);
        h_cmd.opcode  = (FANFARE_LEG != 0) ? OP_FANFARE : OP_MOVE;
        h_cmd.heading = d.dx[2] ? HEAD_W : HEAD_E;
        h_cmd.squares = 4'(dx_mag);
    end

    assign vert_cmd = v_cmd;
    assign horz_cmd = h_cmd;
    assign illegal  = !$onehot(move);

endmodule

// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer: UART pass-through when idle, two-leg move replay during a tour.
module tour_cmd_seq
    import tour_pkg::*;
#(
    parameter  int unsigned MAX_MOVES   = 24,
    parameter  int unsigned FANFARE_LEG = 1,
    localparam int unsigned IDXW        = $clog2(MAX_MOVES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_tour,
    input  logic [IDXW-1:0] num_moves,
    input  logic [7:0]      move,
    output logic [IDXW-1:0] mv_indx,
    input  logic [15:0]     cmd_UART,
    input  logic            cmd_rdy_UART,
    input  logic            clr_cmd_rdy,
    input  logic            send_resp,
    input  logic            abort,
    output logic [15:0]     cmd,
    output logic            cmd_rdy,
    output logic [7:0]      resp,
    output logic            busy,
    output logic            tour_done
);

    localparam int unsigned CNTW = $clog2(MAX_MOVES + 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic [CMD_W-1:0]  hold_q, hold_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [CMD_W-1:0]  vert_cmd;
    logic [CMD_W-1:0]  horz_cmd;
    logic              illegal;
    logic [CMD_W-1:0]  cmd_c;
    logic              cmd_rdy_c;
    logic              last_move;
    logic [CNTW-1:0]   num_clamped;

    knight_move_decode #(
        .FANFARE_LEG (FANFARE_LEG)
    ) u_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd),
        .illegal  (illegal)
    );

    assign last_move   = (CNTW'(idx_q) == (cnt_q - CNTW'(1)));
    assign num_clamped = ((num_moves == '0) || (CNTW'(num_moves) > CNTW'(MAX_MOVES)))
                         ? CNTW'(MAX_MOVES) : CNTW'(num_moves);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= CNTW'(MAX_MOVES);
            resp_q  <= RESP_IDLE;
            hold_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        cmd_c     = hold_q;
        cmd_rdy_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_c     = cmd_UART;
                cmd_rdy_c = cmd_rdy_UART;
                if (start_tour) begin
                    state_d = ST_VERT;
                    idx_d   = '0;
                    cnt_d   = num_clamped;
                    resp_d  = RESP_IDLE;
                end
            end
            ST_VERT: begin
                cmd_c     = vert_cmd;
                cmd_rdy_c = !illegal;
                hold_d    = vert_cmd;
                if (clr_cmd_rdy) state_d = ST_HOLDV;
            end
            ST_HOLDV: begin
                if (send_resp) begin
                    state_d = ST_HORZ;
                    resp_d  = RESP_ACK;
                end
            end
            ST_HORZ: begin
                cmd_c     = horz_cmd;
                cmd_rdy_c = 1'b1;
                hold_d    = horz_cmd;
                if (clr_cmd_rdy) state_d = ST_HOLDH;
            end
            ST_HOLDH: begin
                if (send_resp) begin
                    if (last_move) begin
                        state_d = ST_IDLE;
                        resp_d  = RESP_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_VERT;
                        idx_d   = idx_q + IDXW'(1);
                        resp_d  = RESP_ACK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort and a non-one-hot move both end the tour with an error response.
        if ((state_q != ST_IDLE) && (abort || ((state_q == ST_VERT) && illegal))) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            resp_d  = RESP_ERR;
            done_d  = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign mv_indx   = idx_q;
    assign cmd       = cmd_c;
    assign cmd_rdy   = cmd_rdy_c;
    assign resp      = resp_q;
    assign busy      = busy_q;
    assign tour_done = done_q;

endmodule
